// File: rtl/multicycle_ctrl_pkg.sv
// Shared types, opcode/function constants and the instruction decoder
// for the multi-cycle MIPS-subset control sequencer.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_TRAP = 3'd7
   } state_t;

   // Instruction classes; each class follows one path through the FSM
   typedef enum logic [3:0] {
      K_RALU  = 4'd0,
      K_SHIFT = 4'd1,
      K_JR    = 4'd2,
      K_IALU  = 4'd3,
      K_LW    = 4'd4,
      K_SW    = 4'd5,
      K_BEQ   = 4'd6,
      K_BNE   = 4'd7,
      K_J     = 4'd8,
      K_JAL   = 4'd9,
      K_ILL   = 4'd15
   } kind_t;

   typedef struct packed {
      kind_t      kind;
      logic [3:0] aluc;
      logic       aluqa;
      logic       aluqb;
      logic       se;
   } dec_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;
   localparam logic [5:0] FN_JR  = 6'b001000;

   localparam logic [3:0] ALUC_ADD = 4'b0000;
   localparam logic [3:0] ALUC_SUB = 4'b0100;
   localparam logic [3:0] ALUC_AND = 4'b0001;
   localparam logic [3:0] ALUC_OR  = 4'b0101;
   localparam logic [3:0] ALUC_XOR = 4'b0010;
   localparam logic [3:0] ALUC_LUI = 4'b0110;
   localparam logic [3:0] ALUC_SLL = 4'b0011;
   localparam logic [3:0] ALUC_SRL = 4'b0111;
   localparam logic [3:0] ALUC_SRA = 4'b1111;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JR  = 2'b10;
   localparam logic [1:0] PCSRC_JMP = 2'b11;

   // Classifies an instruction and derives the ALU selects it needs from EX onward
   function automatic dec_t decode(input logic [5:0] op, input logic [5:0] func);
      dec_t d;
      d.kind  = K_ILL;
      d.aluc  = ALUC_ADD;
      d.se    = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (func)
               FN_ADD:  begin d.kind = K_RALU;  d.aluc = ALUC_ADD; end
               FN_SUB:  begin d.kind = K_RALU;  d.aluc = ALUC_SUB; end
               FN_AND:  begin d.kind = K_RALU;  d.aluc = ALUC_AND; end
               FN_OR:   begin d.kind = K_RALU;  d.aluc = ALUC_OR;  end
               FN_XOR:  begin d.kind = K_RALU;  d.aluc = ALUC_XOR; end
               FN_SLL:  begin d.kind = K_SHIFT; d.aluc = ALUC_SLL; end
               FN_SRL:  begin d.kind = K_SHIFT; d.aluc = ALUC_SRL; end
               FN_SRA:  begin d.kind = K_SHIFT; d.aluc = ALUC_SRA; end
               FN_JR:   begin d.kind = K_JR; end
               default: begin d.kind = K_ILL; end
            endcase
         end
         OP_ADDI: begin d.kind = K_IALU; d.aluc = ALUC_ADD; d.se = 1'b1; end
         OP_ANDI: begin d.kind = K_IALU; d.aluc = ALUC_AND; end
         OP_ORI:  begin d.kind = K_IALU; d.aluc = ALUC_OR;  end
         OP_XORI: begin d.kind = K_IALU; d.aluc = ALUC_XOR; end
         OP_LUI:  begin d.kind = K_IALU; d.aluc = ALUC_LUI; end
         OP_LW:   begin d.kind = K_LW;   d.aluc = ALUC_ADD; d.se = 1'b1; end
         OP_SW:   begin d.kind = K_SW;   d.aluc = ALUC_ADD; d.se = 1'b1; end
         OP_BEQ:  begin d.kind = K_BEQ;  d.aluc = ALUC_SUB; d.se = 1'b1; end
         OP_BNE:  begin d.kind = K_BNE;  d.aluc = ALUC_SUB; d.se = 1'b1; end
         OP_J:    begin d.kind = K_J;   end
         OP_JAL:  begin d.kind = K_JAL; end
         default: begin d.kind = K_ILL; end
      endcase
      // Shifts take the sa field on X; register-register ops and compares take Qb on Y
      d.aluqa = (d.kind == K_SHIFT);
      d.aluqb = (d.kind == K_RALU) || (d.kind == K_SHIFT) ||
                (d.kind == K_BEQ)  || (d.kind == K_BNE);
      return d;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the sequencer (slave) and the datapath (master).
interface multicycle_ctrl_if #(parameter int ICNT_W = 32);
   logic [5:0]        Op;
   logic [5:0]        Func;
   logic              Z;
   logic              Imem_rdy;
   logic              Dmem_rdy;
   logic              Pcwr;
   logic              Irwr;
   logic [1:0]        Pcsrc;
   logic              Regrt;
   logic              Se;
   logic              Aluqa;
   logic              Aluqb;
   logic [3:0]        Aluc;
   logic              Rmem;
   logic              Wmem;
   logic              Reg2reg;
   logic              Jal;
   logic              Wreg;
   logic [2:0]        State;
   logic              Trap;
   logic              Retire;
   logic [ICNT_W-1:0] Icnt;

   modport slave (
      input  Op, Func, Z, Imem_rdy, Dmem_rdy,
      output Pcwr, Irwr, Pcsrc, Regrt, Se, Aluqa, Aluqb, Aluc, Rmem, Wmem,
             Reg2reg, Jal, Wreg, State, Trap, Retire, Icnt
   );

   modport master (
      output Op, Func, Z, Imem_rdy, Dmem_rdy,
      input  Pcwr, Irwr, Pcsrc, Regrt, Se, Aluqa, Aluqb, Aluc, Rmem, Wmem,
             Reg2reg, Jal, Wreg, State, Trap, Retire, Icnt
   );
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory wait timer shared by the IF and MEM states; expired flags the last
// permitted cycle so a ready arriving in that cycle still wins.
module mc_wait_timer #(
   parameter int WAIT_MAX = 15
) (
   input  logic Clk,
   input  logic Clr,
   input  logic clear,
   input  logic count,
   output logic expired
);
   localparam int            CW    = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX - 1);
   localparam logic [CW-1:0] ONE   = CW'(1);

   logic [CW-1:0] cnt_r;

   // Count non-ready cycles since the waiting state was entered
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (count && !expired) begin
         cnt_r <= cnt_r + ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = (cnt_r == LIMIT);
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer with memory-ready handshakes,
// illegal-opcode and memory-timeout trap, and a retired-instruction counter.
module multicycle_ctrl #(
   parameter int WAIT_MAX = 15,
   parameter int ICNT_W   = 32
) (
   input  logic                Clk,
   input  logic                Clr,
   multicycle_ctrl_if.slave    bus
);
   import mc_ctrl_pkg::*;

   localparam logic [ICNT_W-1:0] ICNT_ONE = ICNT_W'(1);

   state_t            state_r;
   state_t            next_state_s;
   dec_t              dec_s;
   logic              expired_s;
   logic              count_s;
   logic              clear_s;
   logic [ICNT_W-1:0] icnt_r;
   logic              pcwr_s, irwr_s, regrt_s, se_s, aluqa_s, aluqb_s;
   logic              rmem_s, wmem_s, reg2reg_s, jal_s, wreg_s;
   logic [1:0]        pcsrc_s;
   logic [3:0]        aluc_s;

   assign dec_s = decode(bus.Op, bus.Func);

   // Timer restarts whenever IF or MEM is entered from another state
   assign clear_s = ((next_state_s == S_IF) || (next_state_s == S_MEM)) &&
                    (next_state_s != state_r);

   mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
      .Clk     (Clk),
      .Clr     (Clr),
      .clear   (clear_s),
      .count   (count_s),
      .expired (expired_s)
   );

   // FSM state register
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         state_r <= S_IF;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and Mealy output decode; everything held at 0 while Clr is high
   always_comb begin
      next_state_s = state_r;
      count_s      = 1'b0;
      pcwr_s       = 1'b0;
      irwr_s       = 1'b0;
      pcsrc_s      = PCSRC_SEQ;
      regrt_s      = 1'b0;
      se_s         = 1'b0;
      aluqa_s      = 1'b0;
      aluqb_s      = 1'b0;
      aluc_s       = ALUC_ADD;
      rmem_s       = 1'b0;
      wmem_s       = 1'b0;
      reg2reg_s    = 1'b0;
      jal_s        = 1'b0;
      wreg_s       = 1'b0;
      if (Clr) begin
         next_state_s = S_IF;
      end else begin
         // ALU selects stay on from EX through WB of the same instruction
         if ((state_r == S_EX) || (state_r == S_MEM) || (state_r == S_WB)) begin
            aluc_s  = dec_s.aluc;
            aluqa_s = dec_s.aluqa;
            aluqb_s = dec_s.aluqb;
            se_s    = dec_s.se;
         end else begin
            aluc_s  = ALUC_ADD;
         end
         case (state_r)
            S_IF: begin
               if (bus.Imem_rdy) begin
                  irwr_s       = 1'b1;
                  next_state_s = S_ID;
               end else if (expired_s) begin
                  next_state_s = S_TRAP;
               end else begin
                  count_s = 1'b1;
               end
            end
            S_ID: begin
               case (dec_s.kind)
                  K_J:   begin pcwr_s = 1'b1; pcsrc_s = PCSRC_JMP; next_state_s = S_IF; end
                  K_JAL: begin
                     pcwr_s = 1'b1; pcsrc_s = PCSRC_JMP; jal_s = 1'b1; wreg_s = 1'b1;
                     next_state_s = S_IF;
                  end
                  K_JR:    begin pcwr_s = 1'b1; pcsrc_s = PCSRC_JR; next_state_s = S_IF; end
                  K_ILL:   begin next_state_s = S_TRAP; end
                  default: begin next_state_s = S_EX; end
               endcase
            end
            S_EX: begin
               case (dec_s.kind)
                  K_BEQ: begin
                     pcwr_s = 1'b1; pcsrc_s = bus.Z ? PCSRC_BR : PCSRC_SEQ; next_state_s = S_IF;
                  end
                  K_BNE: begin
                     pcwr_s = 1'b1; pcsrc_s = bus.Z ? PCSRC_SEQ : PCSRC_BR; next_state_s = S_IF;
                  end
                  K_LW, K_SW:              begin next_state_s = S_MEM; end
                  K_RALU, K_SHIFT, K_IALU: begin next_state_s = S_WB; end
                  default:                 begin next_state_s = S_TRAP; end
               endcase
            end
            S_MEM: begin
               rmem_s = (dec_s.kind == K_LW);
               wmem_s = (dec_s.kind == K_SW);
               if ((dec_s.kind != K_LW) && (dec_s.kind != K_SW)) begin
                  next_state_s = S_TRAP;
               end else if (bus.Dmem_rdy) begin
                  if (dec_s.kind == K_SW) begin
                     pcwr_s       = 1'b1;
                     next_state_s = S_IF;
                  end else begin
                     next_state_s = S_WB;
                  end
               end else if (expired_s) begin
                  next_state_s = S_TRAP;
               end else begin
                  count_s = 1'b1;
               end
            end
            S_WB: begin
               wreg_s       = 1'b1;
               pcwr_s       = 1'b1;
               regrt_s      = (dec_s.kind != K_RALU) && (dec_s.kind != K_SHIFT);
               reg2reg_s    = (dec_s.kind != K_LW);
               next_state_s = S_IF;
            end
            S_TRAP:  begin next_state_s = S_TRAP; end
            default: begin next_state_s = S_TRAP; end
         endcase
      end
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         icnt_r <= '0;
      end else if (pcwr_s) begin
         icnt_r <= icnt_r + ICNT_ONE;
      end else begin
         icnt_r <= icnt_r;
      end
   end

   assign bus.Pcwr    = pcwr_s;
   assign bus.Retire  = pcwr_s;
   assign bus.Irwr    = irwr_s;
   assign bus.Pcsrc   = pcsrc_s;
   assign bus.Regrt   = regrt_s;
   assign bus.Se      = se_s;
   assign bus.Aluqa   = aluqa_s;
   assign bus.Aluqb   = aluqb_s;
   assign bus.Aluc    = aluc_s;
   assign bus.Rmem    = rmem_s;
   assign bus.Wmem    = wmem_s;
   assign bus.Reg2reg = reg2reg_s;
   assign bus.Jal     = jal_s;
   assign bus.Wreg    = wreg_s;
   assign bus.State   = state_r;
   assign bus.Trap    = (state_r == S_TRAP);
   assign bus.Icnt    = icnt_r;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: the driver pushes the expected
// retire record per instruction, the monitor pops and compares on each Retire.
module tb_multicycle_ctrl;
   localparam int WAIT_MAX = 4;
   localparam int K_R = 0, K_SH = 1, K_JR = 2, K_I = 3, K_LW = 4, K_SW = 5,
                  K_BEQ = 6, K_BNE = 7, K_J = 8, K_JAL = 9;
   localparam int I_ADD = 0, I_LW = 14, I_SW = 15, I_BEQ = 16, I_BNE = 17,
                  I_J = 18, I_JAL = 19, I_JR = 8;

   logic Clk = 1'b0;
   logic Clr;
   always #5 Clk = ~Clk;

   multicycle_ctrl_if #(.ICNT_W(32)) bus ();
   multicycle_ctrl #(.WAIT_MAX(WAIT_MAX), .ICNT_W(32)) dut (.Clk(Clk), .Clr(Clr), .bus(bus));

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [11:0] sel; logic [39:0] cnts; logic [31:0] icnt; } exp_t;
   typedef struct { logic [5:0] op; logic [5:0] func; int kind; logic [3:0] aluc; bit se; } ins_t;
   exp_t        sb_q[$];
   ins_t        cat[$];
   logic [31:0] icnt_model;

   function automatic void add_ins(input logic [5:0] op, input logic [5:0] func,
                                   input int kind, input logic [3:0] aluc, input bit se);
      ins_t x;
      x.op = op; x.func = func; x.kind = kind; x.aluc = aluc; x.se = se;
      cat.push_back(x);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Clr = 1'b1;
      tick();
      Clr = 1'b0;
      icnt_model = 32'd0;
   endtask

   // One instruction: expected retire record from the latency/select rules, then cycle-accurate drive
   task automatic run_instr(input int idx, input bit z, input int wi, input int wd);
      ins_t       in;
      exp_t       e;
      int         total, nrmem, nwmem, nwreg;
      logic [1:0] pcsrc;
      bit         jal, regrt, reg2reg, aluqa, aluqb, is_mem, is_br;
      in = cat[idx];
      nrmem = 0; nwmem = 0; nwreg = 0; pcsrc = 2'b00; jal = 1'b0; regrt = 1'b0; reg2reg = 1'b0;
      total = wi + 4;
      case (in.kind)
         K_J:   begin total = wi + 2; pcsrc = 2'b11; end
         K_JAL: begin total = wi + 2; pcsrc = 2'b11; jal = 1'b1; nwreg = 1; end
         K_JR:  begin total = wi + 2; pcsrc = 2'b10; end
         K_BEQ: begin total = wi + 3; pcsrc = z ? 2'b01 : 2'b00; end
         K_BNE: begin total = wi + 3; pcsrc = z ? 2'b00 : 2'b01; end
         K_R, K_SH: begin regrt = 1'b0; reg2reg = 1'b1; nwreg = 1; end
         K_I:   begin regrt = 1'b1; reg2reg = 1'b1; nwreg = 1; end
         K_LW:  begin total = wi + wd + 5; regrt = 1'b1; nwreg = 1; nrmem = wd + 1; end
         K_SW:  begin total = wi + wd + 4; nwmem = wd + 1; end
         default: begin total = wi + 4; end
      endcase
      aluqa  = (in.kind == K_SH);
      aluqb  = (in.kind == K_R) || (in.kind == K_SH) || (in.kind == K_BEQ) || (in.kind == K_BNE);
      is_mem = (in.kind == K_LW) || (in.kind == K_SW);
      is_br  = (in.kind == K_BEQ) || (in.kind == K_BNE);
      e.cyc  = cyc + total - 1;
      e.sel  = {pcsrc, jal, regrt, reg2reg, in.aluc, aluqa, aluqb, in.se};
      e.cnts = {8'd1, 8'(nrmem), 8'(nwmem), 8'(nwreg), 8'd1};
      e.icnt = icnt_model;
      icnt_model = icnt_model + 32'd1;
      sb_q.push_back(e);
      for (int k = 0; k < total; k++) begin
         if (k <= wi) begin
            bus.Op       = 6'($urandom);
            bus.Func     = 6'($urandom);
            bus.Imem_rdy = (k == wi);
         end else begin
            bus.Op       = in.op;
            bus.Func     = in.func;
            bus.Imem_rdy = 1'($urandom_range(0, 1));
         end
         bus.Dmem_rdy = (is_mem && k >= wi + 3) ? (k == wi + 3 + wd) : 1'($urandom_range(0, 1));
         bus.Z        = (is_br && k == wi + 2) ? z : 1'($urandom_range(0, 1));
         tick();
      end
   endtask

   // Monitor: accumulate strobes per instruction, compare against the scoreboard on Retire
   initial begin
      int   n_irwr, n_rmem, n_wmem, n_wreg, n_pcwr;
      exp_t e;
      n_irwr = 0; n_rmem = 0; n_wmem = 0; n_wreg = 0; n_pcwr = 0;
      forever begin
         @(negedge Clk);
         if (Clr) begin
            n_irwr = 0; n_rmem = 0; n_wmem = 0; n_wreg = 0; n_pcwr = 0;
         end else begin
            n_irwr += int'(bus.Irwr);
            n_rmem += int'(bus.Rmem);
            n_wmem += int'(bus.Wmem);
            n_wreg += int'(bus.Wreg);
            n_pcwr += int'(bus.Pcwr);
            if (bus.Retire) begin
               if (sb_q.size() == 0) begin
                  vectors++;
                  errors++;
                  $display("FAIL unexpected_retire: got Retire at cycle %0d, expected none", cyc);
               end else begin
                  e = sb_q.pop_front();
                  check("retire_cycle", 64'(cyc), 64'(e.cyc));
                  check("selects", {bus.Pcsrc, bus.Jal, bus.Regrt, bus.Reg2reg, bus.Aluc,
                                    bus.Aluqa, bus.Aluqb, bus.Se}, e.sel);
                  check("strobe_counts", {8'(n_irwr), 8'(n_rmem), 8'(n_wmem), 8'(n_wreg),
                                          8'(n_pcwr)}, e.cnts);
                  check("icnt", bus.Icnt, e.icnt);
               end
               n_irwr = 0; n_rmem = 0; n_wmem = 0; n_wreg = 0; n_pcwr = 0;
            end
         end
      end
   end

   initial begin
      add_ins(6'b000000, 6'b100000, K_R,   4'b0000, 1'b0); // add
      add_ins(6'b000000, 6'b100010, K_R,   4'b0100, 1'b0); // sub
      add_ins(6'b000000, 6'b100100, K_R,   4'b0001, 1'b0); // and
      add_ins(6'b000000, 6'b100101, K_R,   4'b0101, 1'b0); // or
      add_ins(6'b000000, 6'b100110, K_R,   4'b0010, 1'b0); // xor
      add_ins(6'b000000, 6'b000000, K_SH,  4'b0011, 1'b0); // sll
      add_ins(6'b000000, 6'b000010, K_SH,  4'b0111, 1'b0); // srl
      add_ins(6'b000000, 6'b000011, K_SH,  4'b1111, 1'b0); // sra
      add_ins(6'b000000, 6'b001000, K_JR,  4'b0000, 1'b0); // jr
      add_ins(6'b001000, 6'b010101, K_I,   4'b0000, 1'b1); // addi
      add_ins(6'b001100, 6'b010101, K_I,   4'b0001, 1'b0); // andi
      add_ins(6'b001101, 6'b010101, K_I,   4'b0101, 1'b0); // ori
      add_ins(6'b001110, 6'b010101, K_I,   4'b0010, 1'b0); // xori
      add_ins(6'b001111, 6'b010101, K_I,   4'b0110, 1'b0); // lui
      add_ins(6'b100011, 6'b010101, K_LW,  4'b0000, 1'b1); // lw
      add_ins(6'b101011, 6'b010101, K_SW,  4'b0000, 1'b1); // sw
      add_ins(6'b000100, 6'b010101, K_BEQ, 4'b0100, 1'b1); // beq
      add_ins(6'b000101, 6'b010101, K_BNE, 4'b0100, 1'b1); // bne
      add_ins(6'b000010, 6'b010101, K_J,   4'b0000, 1'b0); // j
      add_ins(6'b000011, 6'b010101, K_JAL, 4'b0000, 1'b0); // jal

      Clr = 1'b1; icnt_model = 32'd0;
      bus.Op = 6'd0; bus.Func = 6'd0; bus.Z = 1'b1; bus.Imem_rdy = 1'b1; bus.Dmem_rdy = 1'b1;
      repeat (2) tick();
      check("reset_state", {bus.State, bus.Trap, bus.Icnt}, {3'd0, 1'b0, 32'd0});
      check("reset_strobes", {bus.Pcwr, bus.Irwr, bus.Wreg, bus.Rmem, bus.Wmem, bus.Retire}, 6'd0);
      Clr = 1'b0;

      // Directed opening sequence, then a random stream
      run_instr(I_ADD, 1'b0, 0, 0);
      run_instr(I_LW,  1'b0, 0, 3);
      run_instr(I_BEQ, 1'b1, 0, 0);
      run_instr(I_BEQ, 1'b0, 1, 0);
      run_instr(I_BNE, 1'b1, 0, 0);
      run_instr(I_BNE, 1'b0, 2, 0);
      run_instr(I_JAL, 1'b0, 0, 0);
      run_instr(I_J,   1'b0, 3, 0);
      run_instr(I_JR,  1'b0, 0, 0);
      run_instr(I_SW,  1'b0, 0, 3);
      repeat (150) run_instr($urandom_range(0, 19), 1'($urandom_range(0, 1)),
                             $urandom_range(0, WAIT_MAX - 1), $urandom_range(0, WAIT_MAX - 1));

      // Reset in the middle of a store's MEM phase
      bus.Op = 6'b101011; bus.Func = 6'd0; bus.Imem_rdy = 1'b1; bus.Dmem_rdy = 1'b0;
      tick();
      bus.Imem_rdy = 1'b0;
      tick();
      tick();
      check("sw_in_mem", {bus.State, bus.Wmem}, {3'd3, 1'b1});
      #2 Clr = 1'b1;
      #1 check("reset_mid_mem", {bus.State, bus.Wmem, bus.Pcwr, bus.Icnt}, {3'd0, 1'b0, 1'b0, 32'd0});
      icnt_model = 32'd0;
      tick();
      Clr = 1'b0;
      run_instr(I_ADD, 1'b0, 0, 0);
      run_instr(I_LW,  1'b0, 1, 2);

      // Illegal opcode traps after ID and stays trapped
      bus.Op = 6'b111111; bus.Imem_rdy = 1'b1;
      tick();
      check("illegal_id", {bus.State, bus.Pcwr, bus.Irwr}, {3'd1, 1'b0, 1'b0});
      bus.Imem_rdy = 1'b0;
      tick();
      for (int i = 0; i < 20; i++) begin
         check("trap_hold", {bus.State, bus.Trap, bus.Pcwr, bus.Irwr, bus.Wreg, bus.Rmem, bus.Wmem},
               {3'd7, 1'b1, 5'd0});
         bus.Imem_rdy = 1'($urandom_range(0, 1));
         bus.Dmem_rdy = 1'($urandom_range(0, 1));
         bus.Op       = 6'($urandom);
         tick();
      end
      do_reset();
      check("trap_cleared", {bus.State, bus.Trap}, {3'd0, 1'b0});

      // Data memory never ready: trap after WAIT_MAX MEM cycles
      bus.Op = 6'b100011; bus.Imem_rdy = 1'b1; bus.Dmem_rdy = 1'b0;
      tick();
      bus.Imem_rdy = 1'b0;
      tick();
      tick();
      for (int m = 0; m < WAIT_MAX; m++) begin
         check("mem_wait", {bus.State, bus.Rmem, bus.Trap}, {3'd3, 1'b1, 1'b0});
         tick();
      end
      check("dmem_timeout", {bus.State, bus.Trap, bus.Rmem}, {3'd7, 1'b1, 1'b0});
      do_reset();

      // Instruction memory never ready: trap after WAIT_MAX IF cycles
      bus.Imem_rdy = 1'b0;
      for (int m = 0; m < WAIT_MAX; m++) begin
         check("if_wait", {bus.State, bus.Irwr}, {3'd0, 1'b0});
         tick();
      end
      check("imem_timeout", {bus.State, bus.Trap}, {3'd7, 1'b1});
      do_reset();
      run_instr(I_ADD, 1'b0, 0, 0);

      repeat (3) tick();
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
